// File: rtl/mem_wb_stage_if.sv
// EX->WB bundle for the memory stage: hazard controls, EX op fields, registered write-back fields.
// No timing of its own; the stage answers ex_* one edge later on wb_* and misalign_err.
// Backpressure: stall freezes wb_* and blocks accept; flush kills the incoming op.
interface mem_wb_stage_if #(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
);
    logic             stall;
    logic             flush;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_alu_res;
    logic [XLEN-1:0]  ex_store_data;
    logic             ex_is_jump;
    logic             ex_reg_we;
    logic [REG_W-1:0] ex_rd;
    logic             ex_mem_re;
    logic             ex_mem_we;
    logic [1:0]       ex_size;
    logic             ex_unsigned;
    logic             wb_valid;
    logic             wb_reg_we;
    logic [REG_W-1:0] wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             misalign_err;

    modport master (
        output stall, flush, ex_valid, ex_alu_res, ex_store_data, ex_is_jump,
               ex_reg_we, ex_rd, ex_mem_re, ex_mem_we, ex_size, ex_unsigned,
        input  wb_valid, wb_reg_we, wb_rd, wb_data, misalign_err
    );

    modport slave (
        input  stall, flush, ex_valid, ex_alu_res, ex_store_data, ex_is_jump,
               ex_reg_we, ex_rd, ex_mem_re, ex_mem_we, ex_size, ex_unsigned,
        output wb_valid, wb_reg_we, wb_rd, wb_data, misalign_err
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM->WB stage: data RAM with byte-lane stores, sign/zero-extended loads, misalign detection.
// Latency: op accepted at edge N drives wb_* in the following cycle (load data straight off the RAM).
// Backpressure: stall holds wb_* and the RAM read data with no write; flush drops the op and wins.
module mem_wb_stage #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 8,
    parameter int REG_W  = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_wb_stage_if.slave bus
);
    localparam int NB = XLEN / 8;

    logic [ADDR_W-1:0] idx;
    logic [1:0]        off;
    logic              accept;
    logic              misalign;
    logic              st_en;
    logic [NB-1:0]     be;
    logic [XLEN-1:0]   wdat;

    logic [XLEN-1:0]   ram_q [2**ADDR_W];
    logic [XLEN-1:0]   rdata_q;

    logic              valid_q, reg_we_q, mis_q, jump_q, re_q, uns_q;
    logic [REG_W-1:0]  rd_q;
    logic [1:0]        off_q, size_q;
    logic [XLEN-1:0]   alu_q, sd_q;
    logic [7:0]        ld_b;
    logic [15:0]       ld_h;
    logic [XLEN-1:0]   ld_val;

    assign idx    = bus.ex_alu_res[ADDR_W+1:2];
    assign off    = bus.ex_alu_res[1:0];
    assign accept = bus.ex_valid & ~bus.stall & ~bus.flush;

    assign misalign = (bus.ex_mem_re | bus.ex_mem_we) &
                      (((bus.ex_size == 2'b01) & off[0]) | (bus.ex_size[1] & (off != 2'b00)));

    // rst_n gating keeps a store presented at a reset edge out of the RAM.
    assign st_en = rst_n & accept & bus.ex_mem_we & ~bus.ex_is_jump & ~misalign;

    always_comb begin
        be   = '1;
        wdat = bus.ex_store_data;
        case (bus.ex_size)
            2'b00: begin
                be   = NB'(1) << off;
                wdat = {NB{bus.ex_store_data[7:0]}};
            end
            2'b01: begin
                be   = NB'(3) << off;
                wdat = {(NB/2){bus.ex_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Read-before-write within an edge; a later load sees the earlier store.
    always_ff @(posedge clk) begin
        if (st_en) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) ram_q[idx][8*i +: 8] <= wdat[8*i +: 8];
            end
        end
        if (!bus.stall) rdata_q <= ram_q[idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            reg_we_q <= 1'b0;
            mis_q    <= 1'b0;
            jump_q   <= 1'b0;
            re_q     <= 1'b0;
            uns_q    <= 1'b0;
            rd_q     <= '0;
            off_q    <= '0;
            size_q   <= '0;
            alu_q    <= '0;
            sd_q     <= '0;
        end else if (bus.flush) begin
            valid_q  <= 1'b0;
            reg_we_q <= 1'b0;
            mis_q    <= 1'b0;
        end else if (!bus.stall) begin
            valid_q  <= bus.ex_valid;
            reg_we_q <= bus.ex_valid & bus.ex_reg_we & ~misalign;
            mis_q    <= bus.ex_valid & misalign;
            jump_q   <= bus.ex_is_jump;
            re_q     <= bus.ex_mem_re;
            uns_q    <= bus.ex_unsigned;
            rd_q     <= bus.ex_rd;
            off_q    <= off;
            size_q   <= bus.ex_size;
            alu_q    <= bus.ex_alu_res;
            sd_q     <= bus.ex_store_data;
        end
    end

    always_comb begin
        ld_b   = rdata_q[8*off_q +: 8];
        ld_h   = rdata_q[16*off_q[1] +: 16];
        ld_val = rdata_q;
        case (size_q)
            2'b00:   ld_val = {{(XLEN-8){~uns_q & ld_b[7]}}, ld_b};
            2'b01:   ld_val = {{(XLEN-16){~uns_q & ld_h[15]}}, ld_h};
            default: ;
        endcase
    end

    assign bus.wb_valid     = valid_q;
    assign bus.wb_reg_we    = reg_we_q;
    assign bus.wb_rd        = rd_q;
    assign bus.wb_data      = jump_q ? sd_q : (re_q ? ld_val : alu_q);
    assign bus.misalign_err = mis_q;
endmodule
